// File: rtl/lfc_ram_arbiter.sv
// lfc_ram_arbiter: round-robin arbiter that shares one downstream RAM port
// between the per-bank RAM request channels of the lockup-free cache.
// One bank request is latched at a time and driven to memory until memory
// strobes completion. The returned data and a one-cycle complete pulse then
// go back to the winning bank only.
module lfc_ram_arbiter #(
  parameter  int NUM_BANKS = 4,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  localparam int IDX_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_BANKS-1:0]              bank_REN,
  input  logic [NUM_BANKS-1:0]              bank_WEN,
  input  logic [NUM_BANKS-1:0][ADDR_W-1:0]  bank_addr,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]  bank_store,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]  bank_data,
  output logic [NUM_BANKS-1:0]              bank_complete,
  output logic                              mem_REN,
  output logic                              mem_WEN,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_store,
  input  logic [DATA_W-1:0]                 mem_data,
  input  logic                              mem_complete,
  output logic                              busy,
  output logic [IDX_W-1:0]                  grant_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                             state_r;
  state_t                             next_state_s;
  logic [NUM_BANKS-1:0]               req_s;
  logic                               found_s;
  logic [IDX_W-1:0]                   winner_s;
  int                                 cand_s;
  logic [IDX_W-1:0]                   last_grant_r;
  logic [IDX_W-1:0]                   grant_idx_r;
  logic [ADDR_W-1:0]                  addr_r;
  logic [DATA_W-1:0]                  store_r;
  logic                               rw_r;
  logic                               mem_ren_r;
  logic                               mem_wen_r;
  logic [NUM_BANKS-1:0]               bank_complete_r;
  logic [NUM_BANKS-1:0][DATA_W-1:0]   bank_data_r;
  logic                               busy_r;

  // A bank requests when either enable is set; write takes precedence later.
  assign req_s = bank_REN | bank_WEN;

  // Round-robin pick: first requester after the last served bank, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = last_grant_r;
    cand_s   = 0;
    for (int off = 1; off <= NUM_BANKS; off++) begin
      cand_s = (int'(last_grant_r) + off) % NUM_BANKS;
      if (!found_s && req_s[cand_s]) begin
        found_s  = 1'b1;
        winner_s = IDX_W'(cand_s);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state logic: grant from IDLE, wait for memory in XFER, one turnaround in DONE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          next_state_s = ST_XFER;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (mem_complete) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_XFER;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register; busy is registered alongside so it tracks the new state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != ST_IDLE);
    end
  end

  // Datapath: latch the winner, drive memory, return data and the complete pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r    <= IDX_W'(NUM_BANKS - 1);
      grant_idx_r     <= '0;
      addr_r          <= '0;
      store_r         <= '0;
      rw_r            <= 1'b0;
      mem_ren_r       <= 1'b0;
      mem_wen_r       <= 1'b0;
      bank_complete_r <= '0;
      bank_data_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bank_complete_r <= '0;
          if (found_s) begin
            addr_r       <= bank_addr[winner_s];
            store_r      <= bank_store[winner_s];
            rw_r         <= bank_WEN[winner_s];
            grant_idx_r  <= winner_s;
            last_grant_r <= winner_s;
            mem_ren_r    <= ~bank_WEN[winner_s];
            mem_wen_r    <= bank_WEN[winner_s];
          end else begin
            mem_ren_r    <= 1'b0;
            mem_wen_r    <= 1'b0;
          end
        end
        ST_XFER: begin
          if (mem_complete) begin
            mem_ren_r                    <= 1'b0;
            mem_wen_r                    <= 1'b0;
            bank_complete_r[grant_idx_r] <= 1'b1;
            if (!rw_r) begin
              bank_data_r[grant_idx_r] <= mem_data;
            end else begin
              bank_data_r[grant_idx_r] <= bank_data_r[grant_idx_r];
            end
          end else begin
            bank_complete_r <= '0;
          end
        end
        ST_DONE: begin
          bank_complete_r <= '0;
          mem_ren_r       <= 1'b0;
          mem_wen_r       <= 1'b0;
        end
        default: begin
          bank_complete_r <= '0;
          mem_ren_r       <= 1'b0;
          mem_wen_r       <= 1'b0;
        end
      endcase
    end
  end

  assign mem_REN       = mem_ren_r;
  assign mem_WEN       = mem_wen_r;
  assign mem_addr      = addr_r;
  assign mem_store     = store_r;
  assign bank_complete = bank_complete_r;
  assign bank_data     = bank_data_r;
  assign busy          = busy_r;
  assign grant_idx     = grant_idx_r;

endmodule

// File: tb/tb_lfc_ram_arbiter.sv
// Testbench for lfc_ram_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_lfc_ram_arbiter;

  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NB-1:0]           bank_REN;
  logic [NB-1:0]           bank_WEN;
  logic [NB-1:0][AW-1:0]   bank_addr;
  logic [NB-1:0][DW-1:0]   bank_store;
  logic [NB-1:0][DW-1:0]   bank_data;
  logic [NB-1:0]           bank_complete;
  logic                    mem_REN;
  logic                    mem_WEN;
  logic [AW-1:0]           mem_addr;
  logic [DW-1:0]           mem_store;
  logic [DW-1:0]           mem_data;
  logic                    mem_complete;
  logic                    busy;
  logic [1:0]              grant_idx;

  lfc_ram_arbiter #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .bank_REN(bank_REN), .bank_WEN(bank_WEN),
    .bank_addr(bank_addr), .bank_store(bank_store),
    .bank_data(bank_data), .bank_complete(bank_complete),
    .mem_REN(mem_REN), .mem_WEN(mem_WEN),
    .mem_addr(mem_addr), .mem_store(mem_store),
    .mem_data(mem_data), .mem_complete(mem_complete),
    .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which bank is being served, whether the
  // turnaround cycle is pending, and the expected visible outputs.
  logic          exp_ren, exp_wen, exp_busy;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_store;
  logic [NB-1:0] exp_complete;
  logic [DW-1:0] exp_data [NB];
  int            exp_grant;
  int            m_last;
  int            m_active;
  bit            m_write;
  bit            m_turn;
  bit            compare_en = 1'b0;

  task automatic model_reset();
    exp_ren = 1'b0; exp_wen = 1'b0; exp_busy = 1'b0;
    exp_addr = '0; exp_store = '0; exp_complete = '0;
    for (int b = 0; b < NB; b++) exp_data[b] = '0;
    exp_grant = 0; m_last = NB - 1; m_active = -1;
    m_write = 1'b0; m_turn = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      exp_complete = '0;
      if (m_turn) begin
        m_turn   = 1'b0;
        exp_busy = 1'b0;
      end else if (m_active >= 0) begin
        if (mem_complete) begin
          exp_ren = 1'b0;
          exp_wen = 1'b0;
          exp_complete[m_active] = 1'b1;
          if (!m_write) exp_data[m_active] = mem_data;
          m_active = -1;
          m_turn   = 1'b1;
        end
      end else begin
        for (int off = 1; off <= NB; off++) begin
          int b;
          b = (m_last + off) % NB;
          if (m_active < 0 && (bank_REN[b] || bank_WEN[b])) begin
            m_active  = b;
            m_write   = bank_WEN[b];
            m_last    = b;
            exp_grant = b;
            exp_addr  = bank_addr[b];
            exp_store = bank_store[b];
            exp_ren   = !m_write;
            exp_wen   = m_write;
            exp_busy  = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (compare_en) begin
      check("mem_REN", mem_REN, exp_ren);
      check("mem_WEN", mem_WEN, exp_wen);
      check("mem_addr", mem_addr, exp_addr);
      check("mem_store", mem_store, exp_store);
      check("bank_complete", bank_complete, exp_complete);
      check("busy", busy, exp_busy);
      check("grant_idx", grant_idx, exp_grant);
      for (int b = 0; b < NB; b++) check("bank_data", bank_data[b], exp_data[b]);
    end
  end

  initial begin
    rst = 1'b1; bank_REN = '0; bank_WEN = '0; bank_addr = '0; bank_store = '0;
    mem_data = '0; mem_complete = 1'b0;
    model_reset();
    #1 compare_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", busy, 64'd0);
    check("rst_grant", grant_idx, 64'd0);
    check("rst_mem_REN", mem_REN, 64'd0);

    // Single read from bank 2, memory answers in cycle 3.
    bank_REN = 4'b0100; bank_addr[2] = 32'h0000_1040;
    tick();
    check("rd_mem_REN", mem_REN, 64'd1);
    check("rd_mem_addr", mem_addr, 64'h1040);
    check("rd_grant", grant_idx, 64'd2);
    bank_REN = '0;
    tick(); tick();
    mem_complete = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    mem_complete = 1'b0;
    check("rd_complete", bank_complete, 64'b0100);
    check("rd_data2", bank_data[2], 64'hDEAD_BEEF);
    check("rd_data0", bank_data[0], 64'd0);
    check("rd_ren_drop", mem_REN, 64'd0);
    tick();
    check("rd_idle_complete", bank_complete, 64'd0);
    check("rd_idle_busy", busy, 64'd0);

    // Write from bank 1.
    bank_WEN = 4'b0010; bank_addr[1] = 32'h200; bank_store[1] = 32'h1234_5678;
    tick();
    check("wr_mem_WEN", mem_WEN, 64'd1);
    check("wr_mem_REN", mem_REN, 64'd0);
    check("wr_store", mem_store, 64'h1234_5678);
    check("wr_grant", grant_idx, 64'd1);
    bank_WEN = '0; bank_store[1] = 32'h0;
    tick();
    check("wr_store_hold", mem_store, 64'h1234_5678);
    mem_complete = 1'b1; mem_data = 32'h5555_AAAA;
    tick();
    mem_complete = 1'b0;
    check("wr_complete", bank_complete, 64'b0010);
    check("wr_data1", bank_data[1], 64'd0);
    tick();

    // REN and WEN together on bank 3: treated as a write.
    bank_REN = 4'b1000; bank_WEN = 4'b1000;
    tick();
    check("both_WEN", mem_WEN, 64'd1);
    check("both_REN", mem_REN, 64'd0);
    check("both_grant", grant_idx, 64'd3);
    bank_REN = '0; bank_WEN = '0; mem_complete = 1'b1;
    tick();
    mem_complete = 1'b0;
    check("both_data3", bank_data[3], 64'd0);
    tick();

    // Address change mid-transfer has no effect.
    bank_REN = 4'b0001; bank_addr[0] = 32'h10;
    tick();
    check("hold_grant", grant_idx, 64'd0);
    bank_addr[0] = 32'h20;
    tick();
    check("hold_addr_a", mem_addr, 64'h10);
    tick();
    check("hold_addr_b", mem_addr, 64'h10);
    bank_REN = '0; mem_complete = 1'b1; mem_data = 32'hCAFE_0001;
    tick();
    mem_complete = 1'b0;
    check("hold_data0", bank_data[0], 64'hCAFE_0001);
    tick();

    // Reset during a transfer, then a late mem_complete.
    bank_REN = 4'b0100; bank_addr[2] = 32'h3000;
    tick();
    check("rx_busy", busy, 64'd1);
    rst = 1'b1; model_reset();
    #1;
    check("rx_ren", mem_REN, 64'd0);
    check("rx_busy0", busy, 64'd0);
    check("rx_data0", bank_data[0], 64'd0);
    bank_REN = '0;
    tick();
    rst = 1'b0; mem_complete = 1'b1;
    tick();
    check("rx_no_pulse", bank_complete, 64'd0);
    check("rx_idle", busy, 64'd0);
    bank_REN = 4'b0101;
    tick();
    check("rx_grant0", grant_idx, 64'd0);
    check("rx_ren1", mem_REN, 64'd1);
    bank_REN = '0;
    tick();
    mem_complete = 1'b0;
    check("rx_done_pulse", bank_complete, 64'b0001);
    tick();

    // All banks requesting continuously from reset: grant order 0,1,2,3,0,...
    rst = 1'b1; model_reset();
    tick();
    rst = 1'b0; bank_REN = 4'hF;
    for (int r = 0; r < 8; r++) begin
      tick();
      check("rr_grant", grant_idx, 64'(r % 4));
      mem_complete = 1'b1;
      tick();
      mem_complete = 1'b0;
      check("rr_pulse", bank_complete, 64'd1 << (r % 4));
      tick();
    end
    bank_REN = '0;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; model_reset();
      end else begin
        rst = 1'b0;
      end
      bank_REN = 4'($urandom) & 4'($urandom);
      bank_WEN = 4'($urandom) & 4'($urandom) & 4'($urandom);
      for (int b = 0; b < NB; b++) begin
        bank_addr[b]  = $urandom;
        bank_store[b] = $urandom;
      end
      if (m_turn) begin
        bank_REN[exp_grant] = 1'b0;
        bank_WEN[exp_grant] = 1'b0;
      end
      mem_complete = ($urandom_range(0, 2) == 0);
      mem_data     = $urandom;
      tick();
    end

    rst = 1'b0; bank_REN = '0; bank_WEN = '0; mem_complete = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
